// File: rtl/neureka_tcdm_target_mem.sv
// -----------------------------------------------------------------------------
// neureka_tcdm_target_mem
//
// Single-port TCDM responder (target side of the HCI core protocol). It is
// backed by a byte-enabled word array and answers every granted request with
// exactly one in-order response that carries the request ID. Read responses
// carry the array word. Write responses carry zero data and exist only so the
// initiator's r_valid filter has something to discard. A small
// first-word-fall-through FIFO absorbs r_ready back-pressure.
//
// Ports
//   clk_i      clock, every register updates on the rising edge
//   rst_ni     synchronous active-low reset of control state
//   clear_i    synchronous soft clear of control state; array contents kept
//   enable_i   when low no new grants are given; pending responses still drain
//   req_i      request valid
//   gnt_o      request accepted this cycle (combinational)
//   add_i      byte address; only the word-index bits are used
//   wen_i      1 = read, 0 = write
//   be_i       write byte enables
//   data_i     write data
//   id_i       request ID
//   r_data_o   response data (zero for write responses and when idle)
//   r_valid_o  response valid
//   r_ready_i  initiator accepts the response
//   r_id_o     echoed request ID
//   busy_o     at least one transaction is outstanding
// -----------------------------------------------------------------------------
module neureka_tcdm_target_mem #(
    parameter int unsigned BW              = 256,
    parameter int unsigned DEPTH           = 64,
    parameter int unsigned IW              = 8,
    parameter int unsigned RESP_FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            enable_i,
    input  logic            req_i,
    output logic            gnt_o,
    input  logic [31:0]     add_i,
    input  logic            wen_i,
    input  logic [BW/8-1:0] be_i,
    input  logic [BW-1:0]   data_i,
    input  logic [IW-1:0]   id_i,
    output logic [BW-1:0]   r_data_o,
    output logic            r_valid_o,
    input  logic            r_ready_i,
    output logic [IW-1:0]   r_id_o,
    output logic            busy_o
);

    localparam int unsigned NB    = BW / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(RESP_FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0] MAX_OUT  = CNT_W'(RESP_FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RESP_FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // -------------------------------------------------------------------------
    // Storage and state
    // -------------------------------------------------------------------------
    logic [BW-1:0]    mem_q [DEPTH];
    logic [BW-1:0]    rd_data_q;        // registered array read port

    logic             s1_valid_q;       // transaction granted at the last edge
    logic             s1_rd_q;
    logic [IW-1:0]    s1_id_q;

    logic [BW-1:0]    fifo_data_q [RESP_FIFO_DEPTH];
    logic [IW-1:0]    fifo_id_q   [RESP_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

    logic [IDX_W-1:0] idx;
    logic             gnt;
    logic             hs;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [BW-1:0]    s1_resp_data;

    // Upper address bits and byte-offset bits are deliberately ignored.
    logic             unused_add;
    assign unused_add = ^add_i;

    assign idx = add_i[OFF_W +: IDX_W];

    // The outstanding limit covers the in-flight stage plus the FIFO, so a
    // granted transaction always has a FIFO slot if it cannot leave directly.
    assign gnt   = req_i & enable_i & ~clear_i & rst_ni & (out_cnt_q < MAX_OUT);
    assign gnt_o = gnt;

    // -------------------------------------------------------------------------
    // Word array: byte-enabled write, registered read
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (gnt) begin
            if (wen_i) begin
                rd_data_q <= mem_q[idx];
            end else begin
                for (int b = 0; b < NB; b++) begin
                    if (be_i[b]) begin
                        mem_q[idx][b*8 +: 8] <= data_i[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign s1_resp_data = s1_rd_q ? rd_data_q : '0;

    // -------------------------------------------------------------------------
    // Response path: the stage register bypasses the FIFO when it is empty,
    // otherwise it is queued behind older responses. A response that is not
    // taken directly moves into the FIFO unchanged, so the output stays stable.
    // -------------------------------------------------------------------------
    assign fifo_empty = (fifo_cnt_q == '0);
    assign r_valid_o  = ~fifo_empty | s1_valid_q;
    assign hs         = r_valid_o & r_ready_i;
    assign pop        = hs & ~fifo_empty;
    assign push       = s1_valid_q & ~(fifo_empty & r_ready_i);

    always_comb begin
        r_data_o = '0;
        r_id_o   = '0;
        if (!fifo_empty) begin
            r_data_o = fifo_data_q[rd_ptr_q];
            r_id_o   = fifo_id_q[rd_ptr_q];
        end else if (s1_valid_q) begin
            r_data_o = s1_resp_data;
            r_id_o   = s1_id_q;
        end
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        case ({gnt, hs})
            2'b10:   out_cnt_d = out_cnt_q + CNT_ONE;
            2'b01:   out_cnt_d = out_cnt_q - CNT_ONE;
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // FIFO payload needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= s1_resp_data;
            fifo_id_q[wr_ptr_q]   <= s1_id_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            s1_valid_q <= 1'b0;
            s1_rd_q    <= 1'b0;
            s1_id_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            s1_valid_q <= gnt;
            if (gnt) begin
                s1_rd_q <= wen_i;
                s1_id_q <= id_i;
            end
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
            end
            fifo_cnt_q <= fifo_cnt_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    assign busy_o = (out_cnt_q != '0);

    // A handshake always retires a counted transaction, and the FIFO never
    // receives more entries than it holds.
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
        hs |-> (out_cnt_q != '0));
    a_no_fifo_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
        (push && !pop) |-> (fifo_cnt_q < MAX_OUT));

endmodule

// File: tb/tb_neureka_tcdm_target_mem.sv
// -----------------------------------------------------------------------------
// Directed testbench for neureka_tcdm_target_mem with default parameters
// (BW=256, DEPTH=64, IW=8, RESP_FIFO_DEPTH=2). Inputs change 1 ns after the
// rising edge; outputs are sampled 5 ns after the edge.
// -----------------------------------------------------------------------------
module tb_neureka_tcdm_target_mem;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         enable;
    logic         req;
    logic         gnt;
    logic [31:0]  add;
    logic         wen;
    logic [31:0]  be;
    logic [255:0] wdata;
    logic [7:0]   id;
    logic [255:0] r_data;
    logic         r_valid;
    logic         r_ready;
    logic [7:0]   r_id;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Back-pressure schedule: per cycle, r_ready, request index (-1 = none),
    // expected gnt, expected r_valid, expected response index.
    localparam int BP_N = 9;
    localparam int BP_RDY [BP_N] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
    localparam int BP_K   [BP_N] = '{0, 1, 2, 2, 2, 2, 3, -1, -1};
    localparam int BP_GNT [BP_N] = '{1, 1, 0, 0, 0, 1, 1, 0, 0};
    localparam int BP_RV  [BP_N] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    localparam int BP_RK  [BP_N] = '{0, 0, 0, 0, 0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    neureka_tcdm_target_mem #(
        .BW              (256),
        .DEPTH           (64),
        .IW              (8),
        .RESP_FIFO_DEPTH (2)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clear_i   (clear),
        .enable_i  (enable),
        .req_i     (req),
        .gnt_o     (gnt),
        .add_i     (add),
        .wen_i     (wen),
        .be_i      (be),
        .data_i    (wdata),
        .id_i      (id),
        .r_data_o  (r_data),
        .r_valid_o (r_valid),
        .r_ready_i (r_ready),
        .r_id_o    (r_id),
        .busy_o    (busy)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pat(input int k);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(k);
        return {8{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction with r_ready held high: grant this cycle, response next.
    task automatic txn(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] b, input logic [255:0] d,
                       input logic [7:0] i, input logic [255:0] exp);
        req = 1'b1; wen = w; add = a; be = b; wdata = d; id = i; r_ready = 1'b1;
        #4;
        check({tag, " gnt"}, 256'(gnt), 256'(1));
        tick();
        req = 1'b0;
        #4;
        check({tag, " r_valid"}, 256'(r_valid), 256'(1));
        check({tag, " r_id"}, 256'(r_id), 256'(i));
        check({tag, " r_data"}, r_data, exp);
        tick();
        check({tag, " idle"}, 256'({r_valid, busy}), 256'(0));
        $display("txn %s wen=%0b add=%h id=%h", tag, w, a, i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; enable = 1'b1; req = 1'b1; add = '0;
        wen = 1'b1; be = '0; wdata = '0; id = '0; r_ready = 1'b0;

        // Reset state, with a request held to show no grant during reset
        tick();
        #4;
        check("rst gnt", 256'(gnt), 256'(0));
        check("rst r_valid", 256'(r_valid), 256'(0));
        check("rst r_data", r_data, 256'(0));
        check("rst r_id", 256'(r_id), 256'(0));
        check("rst busy", 256'(busy), 256'(0));
        tick();
        rst_n = 1'b1; req = 1'b0;
        tick();

        // Seed word 3 for the later reset-mid-operation test
        txn("w3", 1'b0, 32'h60, '1, pat(3), 8'h01, 256'(0));

        // Byte-enable write to word 5
        txn("be_all", 1'b0, 32'hA0, '1, '1, 8'h20, 256'(0));
        txn("be_low", 1'b0, 32'hA0, 32'h0000_000F, 256'(0), 8'h21, 256'(0));
        txn("be_rd", 1'b1, 32'hA0, '0, 256'(0), 8'h2A, {{28{8'hFF}}, 32'h0});

        // Back-to-back read-after-write on word 7
        r_ready = 1'b1; req = 1'b1; wen = 1'b0; add = 32'hE0; be = '1;
        wdata = 256'h1234; id = 8'd1;
        #4;
        check("raw wr gnt", 256'(gnt), 256'(1));
        tick();
        wen = 1'b1; id = 8'd2;
        #4;
        check("raw rd gnt", 256'(gnt), 256'(1));
        check("raw rsp1 valid", 256'(r_valid), 256'(1));
        check("raw rsp1 id", 256'(r_id), 256'(1));
        check("raw rsp1 data", r_data, 256'(0));
        tick();
        req = 1'b0;
        #4;
        check("raw rsp2 valid", 256'(r_valid), 256'(1));
        check("raw rsp2 id", 256'(r_id), 256'(2));
        check("raw rsp2 data", r_data, 256'h1234);
        tick();
        check("raw idle", 256'(r_valid), 256'(0));
        $display("txn raw write id=01 read id=02");

        // Address wrap: 0x800 is word 64, which aliases word 0
        txn("wrap_wr", 1'b0, 32'h800, '1, pat(99), 8'h03, 256'(0));
        txn("wrap_rd0", 1'b1, 32'h000, '0, 256'(0), 8'h04, pat(99));
        txn("wrap_rd81f", 1'b1, 32'h81F, '0, 256'(0), 8'h05, pat(99));

        // Back-pressure with four held reads of words 10..13
        for (int k = 0; k < 4; k++) begin
            txn("bp_fill", 1'b0, 32'((10 + k) * 32), '1, pat(10 + k), 8'(8'h30 + k), 256'(0));
        end
        for (int c = 0; c < BP_N; c++) begin
            r_ready = BP_RDY[c][0];
            if (BP_K[c] >= 0) begin
                req = 1'b1; wen = 1'b1; add = 32'((10 + BP_K[c]) * 32);
                id = 8'(8'h40 + BP_K[c]);
            end else begin
                req = 1'b0;
            end
            #4;
            check("bp gnt", 256'(gnt), 256'(BP_GNT[c]));
            check("bp r_valid", 256'(r_valid), 256'(BP_RV[c]));
            if (BP_RV[c] != 0) begin
                check("bp r_id", 256'(r_id), 256'(8'h40 + BP_RK[c]));
                check("bp r_data", r_data, pat(10 + BP_RK[c]));
            end
            $display("bp cycle %0d ready=%0b gnt=%0b r_valid=%0b r_id=%h", c, r_ready, gnt, r_valid, r_id);
            tick();
        end
        check("bp busy", 256'(busy), 256'(0));

        // Streaming: 32 writes then 32 reads, one per cycle
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k <= 32; k++) begin
                r_ready = 1'b1;
                if (k < 32) begin
                    req = 1'b1; wen = (pass == 1); add = 32'((16 + k) * 32);
                    be = '1; wdata = pat(16 + k); id = 8'(k);
                end else begin
                    req = 1'b0;
                end
                #4;
                if (k < 32) check("stream gnt", 256'(gnt), 256'(1));
                if (k > 0) begin
                    check("stream r_valid", 256'(r_valid), 256'(1));
                    check("stream r_id", 256'(r_id), 256'(k - 1));
                    check("stream r_data", r_data, (pass == 1) ? pat(16 + k - 1) : 256'(0));
                    $display("txn stream pass=%0d id=%h", pass, r_id);
                end else begin
                    check("stream first", 256'(r_valid), 256'(0));
                end
                tick();
            end
            check("stream idle", 256'({r_valid, busy}), 256'(0));
        end

        // Reset in the middle of two outstanding reads
        r_ready = 1'b0; req = 1'b1; wen = 1'b1; add = 32'h60; id = 8'h50;
        #4;
        check("mrst gnt0", 256'(gnt), 256'(1));
        tick();
        add = 32'h80; id = 8'h51;
        #4;
        check("mrst gnt1", 256'(gnt), 256'(1));
        check("mrst r_valid", 256'(r_valid), 256'(1));
        tick();
        rst_n = 1'b0;
        #4;
        check("mrst gnt in reset", 256'(gnt), 256'(0));
        check("mrst busy before", 256'(busy), 256'(1));
        tick();
        rst_n = 1'b1; req = 1'b0;
        #4;
        check("mrst r_valid after", 256'(r_valid), 256'(0));
        check("mrst busy after", 256'(busy), 256'(0));
        tick();
        txn("mrst_rd3", 1'b1, 32'h60, '0, 256'(0), 8'h52, pat(3));

        // Soft clear drops a buffered response and blocks a same-cycle request
        r_ready = 1'b0; req = 1'b1; wen = 1'b1; add = 32'hA0; id = 8'h60;
        #4;
        check("clr gnt", 256'(gnt), 256'(1));
        tick();
        clear = 1'b1;
        #4;
        check("clr gnt blocked", 256'(gnt), 256'(0));
        check("clr r_id before", 256'(r_id), 256'(8'h60));
        tick();
        clear = 1'b0; req = 1'b0;
        #4;
        check("clr r_valid", 256'(r_valid), 256'(0));
        check("clr busy", 256'(busy), 256'(0));
        tick();

        // enable low: no new grants, pending response drains
        r_ready = 1'b0; req = 1'b1; wen = 1'b1; add = 32'hE0; id = 8'h70;
        #4;
        check("en gnt", 256'(gnt), 256'(1));
        tick();
        enable = 1'b0;
        #4;
        check("en off gnt", 256'(gnt), 256'(0));
        check("en r_id", 256'(r_id), 256'(8'h70));
        check("en r_data", r_data, 256'h1234);
        tick();
        r_ready = 1'b1;
        #4;
        check("en drain gnt", 256'(gnt), 256'(0));
        check("en drain valid", 256'(r_valid), 256'(1));
        tick();
        req = 1'b0; enable = 1'b1;
        #4;
        check("en done", 256'({r_valid, busy}), 256'(0));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/neureka_tcdm_target_mem.md
Name: neureka_tcdm_target_mem

Overview:
- Single-port TCDM responder (target side of the HCI core protocol) backed by a byte-enabled word array; serves requests from a streamer initiator port.
- Used as a standalone weight-memory model and as the TCDM endpoint in block-level benches.
- Every granted read or write returns exactly one in-order response carrying the request ID. Read responses hold data; write responses exist so the initiator's r_valid filter can discard them.
- Response buffering in a small FIFO supports r_ready back-pressure.

Parameters:
BW, NEUREKA_MEM_BANDWIDTH_EXT, data width in bits; multiple of 8.
DEPTH, 64, number of BW-bit words; power of 2, ≥2.
IW, 8, request/response ID width.
RESP_FIFO_DEPTH, 2, maximum outstanding responses; ≥1.

Ports:
clk_i  in  1  clock, all logic on rising edge.
rst_ni  in  1  synchronous active-low reset.
clear_i  in  1  synchronous soft clear of control state.
enable_i  in  1  when low, no new grants; pending responses still drain.
req_i  in  1  request valid.
gnt_o  out  1  request accepted this cycle.
add_i  in  32  byte address.
wen_i  in  1  1 = read, 0 = write.
be_i  in  BW/8  byte enables for writes.
data_i  in  BW  write data.
id_i  in  IW  request ID.
r_data_o  out  BW  response data.
r_valid_o  out  1  response valid.
r_ready_i  in  1  initiator accepts response.
r_id_o  out  IW  echoed request ID.
busy_o  out  1  outstanding count non-zero.

Behaviour:
- Reset (rst_ni=0 at an edge): gnt_o=0, r_valid_o=0, r_data_o=0, r_id_o=0, busy_o=0, FIFO empty, outstanding counter 0. Array contents are not reset.
- clear_i: same effect on control state as reset; contents kept; in-flight and buffered responses dropped. clear_i overrides a same-cycle request (no grant).
- Word index = add_i[log2(BW/8) +: log2(DEPTH)]. Lower byte-offset bits and upper bits are ignored, so addresses wrap modulo DEPTH words.
- gnt_o (combinational) = req_i & enable_i & ~clear_i & (outstanding < RESP_FIFO_DEPTH). Outstanding counts one-cycle in-flight transactions plus FIFO entries.
- Grant semantics: req_i may be held across cycles; each cycle with gnt_o=1 is one distinct transaction.
- Write: on a granted edge, bytes with be_i[k]=1 are updated; other bytes are kept. be_i is ignored for reads.
- Pipeline: a transaction granted at edge N has its response ready in cycle N+1.
  - Read: array word at the granted index; response data reflects all writes granted before it, so read-after-write on back-to-back cycles returns new data.
  - Write: response data = 0.
- Response FIFO, first-word fall-through: if empty, the response appears on r_valid_o/r_data_o/r_id_o in cycle N+1. Minimum read latency is 1 cycle.
- Once r_valid_o=1, r_data_o and r_id_o stay stable until the r_valid_o & r_ready_i handshake. Responses pop in grant order.
- Full throughput: 1 transaction/cycle when r_ready_i is held high, for any RESP_FIFO_DEPTH ≥2. With depth 1, one transaction per 2 cycles.
- Outstanding counter:
  - +1 on grant, −1 on response handshake; both in the same cycle leaves it unchanged.
  - A grant never occurs with the counter at RESP_FIFO_DEPTH, so no overflow. Underflow is impossible by construction; guard with an assertion.
- busy_o = (outstanding != 0), registered view of the counter.
- enable_i low mid-stream: pending responses still drain; no new grants.
- X on add_i/data_i while req_i=0 has no effect.

Test Plan:
- Reset mid-operation: issue 2 reads, assert rst_ni=0 for 1 cycle while r_ready_i=0 -> r_valid_o=0, busy_o=0 next cycle; a following read of word 3 returns the previously written value (contents kept).
- Byte-enable write: write 0xFF..FF to word 5, then write 0x00..00 with be_i=0x0F -> read of word 5 returns low 4 bytes 0x00, remaining bytes 0xFF, response 1 cycle after grant, r_id_o echoes id 0x2A.
- Back-to-back read-after-write: write word 7 = 0x1234 (id 1) then read word 7 (id 2) on the next cycle, r_ready_i=1 -> responses id 1 (data 0), then id 2 (data 0x1234) on consecutive cycles.
- Back-pressure: RESP_FIFO_DEPTH=2, r_ready_i=0, req_i high with 4 reads -> exactly 2 grants then gnt_o=0. Raise r_ready_i -> responses in order, then the remaining 2 grants; no response lost or duplicated.
- Address wrap: DEPTH=64, BW=256, write word at add_i=0x800 (index 64 mod 64 = 0) -> read at add_i=0x000 returns the same data.
- Streaming: 32 sequential reads with r_ready_i=1 -> 32 grants in 32 cycles, 32 responses on consecutive cycles starting 1 cycle after the first grant.
